// File: rtl/ycbcr2rgb444_pipe.sv
// Streaming YCbCr 8:8:8 to RGB444 converter: 3-stage valid/ready pipeline with
// per-channel clamping and a saturating count of clamped output pixels.
module ycbcr2rgb444_pipe #(
  parameter int SAT_CNT_W = 16,
  parameter int ROUND     = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [23:0]          in_ycbcr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [11:0]          out_rgb,
  input  logic                 sat_clr,
  output logic [SAT_CNT_W-1:0] sat_cnt
);

  localparam logic [SAT_CNT_W-1:0] SAT_ONE = SAT_CNT_W'(1);

  // Returns {clamp_flag, channel}; the shift floors, so any negative sum clamps to 0.
  function automatic logic [8:0] clamp_ch(input logic signed [18:0] x);
    logic signed [18:0] ch;
    ch = x >>> 5'd8;
    if (ch < 19'sd0) begin
      clamp_ch = {1'b1, 8'h00};
    end else if (ch > 19'sd255) begin
      clamp_ch = {1'b1, 8'hFF};
    end else begin
      clamp_ch = {1'b0, ch[7:0]};
    end
  endfunction

  // Round-half-up bumps the nibble when bit 3 is set, except when it is already 0xF.
  function automatic logic [3:0] pack_ch(input logic [7:0] c);
    if ((ROUND != 32'sd0) && c[3] && (c[7:4] != 4'hF)) begin
      pack_ch = c[7:4] + 4'd1;
    end else begin
      pack_ch = c[7:4];
    end
  endfunction

  logic                  w_adv;
  logic                  r_v1, r_v2, r_v3;
  logic [7:0]            r_y1;
  logic signed [8:0]     r_cb1, r_cr1;
  logic signed [18:0]    r_r2, r_g2, r_b2;
  logic [11:0]           r_rgb;
  logic                  r_sat3;
  logic [SAT_CNT_W-1:0]  r_sat_cnt;
  logic signed [18:0]    w_y, w_cb, w_cr;
  logic [8:0]            w_r, w_g, w_b;

  assign w_adv     = !r_v3 || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_v3;
  assign out_rgb   = r_rgb;
  assign sat_cnt   = r_sat_cnt;

  assign w_y  = $signed({11'd0, r_y1});
  assign w_cb = $signed({{10{r_cb1[8]}}, r_cb1});
  assign w_cr = $signed({{10{r_cr1[8]}}, r_cr1});

  assign w_r = clamp_ch(r_r2);
  assign w_g = clamp_ch(r_g2);
  assign w_b = clamp_ch(r_b2);

  // Stage 1: remove the chroma offset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1  <= 1'b0;
      r_y1  <= 8'd0;
      r_cb1 <= 9'sd0;
      r_cr1 <= 9'sd0;
    end else if (w_adv) begin
      r_v1  <= in_valid;
      r_y1  <= in_ycbcr[23:16];
      r_cb1 <= $signed({1'b0, in_ycbcr[15:8]}) - 9'sd128;
      r_cr1 <= $signed({1'b0, in_ycbcr[7:0]}) - 9'sd128;
    end else begin
      r_v1 <= r_v1;
    end
  end

  // Stage 2: fixed-point matrix, coefficients scaled by 256; 19 bits cannot overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2 <= 1'b0;
      r_r2 <= 19'sd0;
      r_g2 <= 19'sd0;
      r_b2 <= 19'sd0;
    end else if (w_adv) begin
      r_v2 <= r_v1;
      r_r2 <= w_y * 19'sd256 + w_cr * 19'sd359;
      r_g2 <= w_y * 19'sd256 - w_cb * 19'sd88 - w_cr * 19'sd183;
      r_b2 <= w_y * 19'sd256 + w_cb * 19'sd454;
    end else begin
      r_v2 <= r_v2;
    end
  end

  // Stage 3: clamp, pack to RGB444 and register the saturation flag with the pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v3   <= 1'b0;
      r_rgb  <= 12'h000;
      r_sat3 <= 1'b0;
    end else if (w_adv) begin
      r_v3   <= r_v2;
      r_rgb  <= {pack_ch(w_r[7:0]), pack_ch(w_g[7:0]), pack_ch(w_b[7:0])};
      r_sat3 <= w_r[8] | w_g[8] | w_b[8];
    end else begin
      r_v3 <= r_v3;
    end
  end

  // Saturation counter: counts only accepted clamped pixels; clear beats increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat_cnt <= '0;
    end else if (sat_clr) begin
      r_sat_cnt <= '0;
    end else if (r_v3 && out_ready && r_sat3 && (r_sat_cnt != '1)) begin
      r_sat_cnt <= r_sat_cnt + SAT_ONE;
    end else begin
      r_sat_cnt <= r_sat_cnt;
    end
  end

endmodule
